// File: rtl/hdmi_video_reconfig_seq.sv
// HDMI video mode reconfiguration sequencer: qualifies the controller mode code,
// decodes it and runs a blank / request / ack / apply / unblank handshake.
module hdmi_video_reconfig_seq #(
  parameter int DATA_WIDTH     = 8,
  parameter int STABLE_CYCLES  = 16,
  parameter int BLANK_CYCLES   = 8,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int IDX_WIDTH      = 4,
  parameter int DEFAULT_IDX    = 0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [IDX_WIDTH-1:0]  cfg_idx,
  output logic                  r2v_f,
  output logic [IDX_WIDTH-1:0]  req_idx,
  output logic                  reconf_req,
  input  logic                  reconf_ack,
  output logic                  blank,
  output logic                  busy,
  output logic                  timeout_err,
  output logic                  unknown_code
);

  localparam int CMAX = (TIMEOUT_CYCLES > BLANK_CYCLES) ? TIMEOUT_CYCLES : BLANK_CYCLES;
  localparam int CW   = $clog2(CMAX + 1);
  localparam int SW   = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] B_LAST   = CW'(BLANK_CYCLES - 1);
  localparam logic [CW-1:0] T_LAST   = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [SW-1:0] S_FULL   = SW'(STABLE_CYCLES);
  localparam logic          DEF_R2V  = (DEFAULT_IDX == 0) || (DEFAULT_IDX == 1);

  typedef enum logic [1:0] {IDLE, BLANK_PRE, REQ, BLANK_POST} state_t;

  // {mapped, r2v, idx[3:0]}
  function automatic logic [5:0] decode(input logic [6:0] c);
    logic [5:0] d;
    casez (c)
      7'h00:       d = {1'b1, 1'b1, 4'd0};
      7'h01:       d = {1'b1, 1'b1, 4'd1};
      7'h02:       d = {1'b1, 1'b0, 4'd2};
      7'h03:       d = {1'b1, 1'b0, 4'd3};
      7'b000_01??: d = {1'b1, 1'b0, 4'd4};
      7'b000_10??: d = {1'b1, 1'b0, 4'd5};
      7'h10:       d = {1'b1, 1'b0, 4'd6};
      7'h11:       d = {1'b1, 1'b0, 4'd7};
      7'h12:       d = {1'b1, 1'b0, 4'd8};
      7'h13:       d = {1'b1, 1'b0, 4'd9};
      7'b010_00??: d = {1'b1, 1'b0, 4'd10};
      7'b100_00??: d = {1'b1, 1'b0, 4'd11};
      default:     d = 6'd0;
    endcase
    return d;
  endfunction

  state_t               state, state_n;
  logic [6:0]           data_q, blk_code;
  logic [SW-1:0]        stable_cnt;
  logic [CW-1:0]        cnt;
  logic [IDX_WIDTH-1:0] pend_idx, dec_idx;
  logic                 pend_r2v, blocked, unk_armed;
  logic [5:0]           dec;
  logic                 changed, qualified;
  logic                 start, req_go, ack_take, tmo, post_done, unk_pulse;
  logic                 unused_data;

  assign unused_data = ^data_in;
  assign changed     = (data_in[6:0] != data_q);
  assign qualified   = (stable_cnt == S_FULL);
  assign dec         = decode(data_q);
  assign dec_idx     = IDX_WIDTH'(dec[3:0]);
  assign busy        = (state != IDLE);

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n   = state;
    start     = 1'b0;
    req_go    = 1'b0;
    ack_take  = 1'b0;
    tmo       = 1'b0;
    post_done = 1'b0;
    unk_pulse = 1'b0;
    case (state)
      IDLE: if (qualified) begin
        if (dec[5] && dec_idx != cfg_idx && !(blocked && data_q == blk_code)) begin
          start   = 1'b1;
          state_n = BLANK_PRE;
        end else if (!dec[5] && unk_armed) begin
          unk_pulse = 1'b1;
        end
      end
      BLANK_PRE: if (cnt == B_LAST) begin
        req_go  = 1'b1;
        state_n = REQ;
      end
      // ack has priority over a timeout landing on the same edge
      REQ: if (reconf_ack) begin
        ack_take = 1'b1;
        state_n  = BLANK_POST;
      end else if (cnt == T_LAST) begin
        tmo     = 1'b1;
        state_n = BLANK_POST;
      end
      BLANK_POST: if (cnt == B_LAST) begin
        post_done = 1'b1;
        state_n   = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      data_q       <= '0;
      stable_cnt   <= '0;
      cnt          <= '0;
      cfg_idx      <= IDX_WIDTH'(DEFAULT_IDX);
      r2v_f        <= DEF_R2V;
      req_idx      <= '0;
      pend_idx     <= '0;
      pend_r2v     <= 1'b0;
      reconf_req   <= 1'b0;
      blank        <= 1'b0;
      timeout_err  <= 1'b0;
      unknown_code <= 1'b0;
      unk_armed    <= 1'b1;
      blocked      <= 1'b0;
      blk_code     <= '0;
    end else begin
      data_q       <= data_in[6:0];
      unknown_code <= unk_pulse;
      if (changed)         stable_cnt <= '0;
      else if (!qualified) stable_cnt <= stable_cnt + SW'(1);
      if (state_n != state || state == IDLE) cnt <= '0;
      else                                   cnt <= cnt + CW'(1);
      // a new code re-arms the unknown pulse even if it fired on this edge
      if (changed)        unk_armed <= 1'b1;
      else if (unk_pulse) unk_armed <= 1'b0;
      if (start) begin
        pend_idx <= dec_idx;
        pend_r2v <= dec[4];
        blank    <= 1'b1;
      end
      if (req_go) begin
        reconf_req <= 1'b1;
        req_idx    <= pend_idx;
      end
      if (ack_take) begin
        reconf_req <= 1'b0;
        cfg_idx    <= pend_idx;
        r2v_f      <= pend_r2v;
      end
      if (tmo) begin
        reconf_req  <= 1'b0;
        timeout_err <= 1'b1;
        blocked     <= 1'b1;
        blk_code    <= data_q;
      end else if (changed) begin
        blocked <= 1'b0;
      end
      if (post_done) blank <= 1'b0;
    end
  end

endmodule

// File: tb/tb_hdmi_video_reconfig_seq.sv
// Bench for hdmi_video_reconfig_seq: timeline-based reference model compared every
// cycle, directed scenarios with literal expectations, then randomized traffic.
module tb_hdmi_video_reconfig_seq;
  localparam int S  = 4;
  localparam int B  = 8;
  localparam int TO = 32;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] data_in = 8'h00;
  logic       reconf_ack = 1'b0;
  logic [3:0] cfg_idx, req_idx;
  logic       r2v_f, reconf_req, blank, busy, timeout_err, unknown_code;

  hdmi_video_reconfig_seq #(
    .DATA_WIDTH(8), .STABLE_CYCLES(S), .BLANK_CYCLES(B),
    .TIMEOUT_CYCLES(TO), .IDX_WIDTH(4), .DEFAULT_IDX(0)
  ) dut (
    .clock(clock), .reset(reset), .data_in(data_in), .cfg_idx(cfg_idx),
    .r2v_f(r2v_f), .req_idx(req_idx), .reconf_req(reconf_req),
    .reconf_ack(reconf_ack), .blank(blank), .busy(busy),
    .timeout_err(timeout_err), .unknown_code(unknown_code)
  );

  always #5 clock = ~clock;

  int tests = 0, fails = 0;
  int tbl [128];

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- reference model: phases timed by absolute cycle numbers
  int   cyc = 0;
  int   m_phase = 0, m_ent = 0, m_chg = 0, m_pend = 0;
  int   m_cfg = 0, m_req_idx = 0, m_code = 0, m_blk_code = 0;
  bit   m_r2v = 1, m_req = 0, m_blank = 0, m_terr = 0, m_unk = 0, m_armed = 1, m_blk = 0;

  always @(posedge clock) begin
    bit qual, timed_out;
    int idx;
    cyc++;
    if (reset) begin
      m_phase = 0; m_cfg = 0; m_r2v = 1; m_req = 0; m_blank = 0; m_terr = 0;
      m_unk = 0; m_code = 0; m_chg = cyc; m_armed = 1; m_blk = 0; m_req_idx = 0;
    end else begin
      qual = (cyc - 1 - m_chg) >= S;
      timed_out = 0;
      m_unk = 0;
      idx = tbl[m_code];
      case (m_phase)
        0: if (qual) begin
          if (idx >= 0 && idx != m_cfg && !(m_blk && m_code == m_blk_code)) begin
            m_phase = 1; m_ent = cyc; m_pend = idx; m_blank = 1;
          end else if (idx < 0 && m_armed) begin
            m_unk = 1; m_armed = 0;
          end
        end
        1: if (cyc - m_ent == B) begin
          m_phase = 2; m_ent = cyc; m_req = 1; m_req_idx = m_pend;
        end
        2: if (reconf_ack) begin
          m_req = 0; m_cfg = m_pend; m_r2v = (m_pend < 2); m_phase = 3; m_ent = cyc;
        end else if (cyc - m_ent == TO) begin
          m_req = 0; m_terr = 1; m_blk = 1; m_blk_code = m_code; timed_out = 1;
          m_phase = 3; m_ent = cyc;
        end
        3: if (cyc - m_ent == B) begin
          m_blank = 0; m_phase = 0;
        end
        default: m_phase = 0;
      endcase
      if (int'(data_in[6:0]) != m_code) begin
        if (!timed_out) m_blk = 0;
        m_armed = 1; m_code = int'(data_in[6:0]); m_chg = cyc;
      end
    end
  end

  // ---------------- compare + event monitors
  int  blank_rises = 0, req_rises = 0, unk_count = 0;
  int  blank_rise_cyc = 0, blank_fall_cyc = 0, req_rise_cyc = 0, req_fall_cyc = 0, req_rise_idx = 0;
  bit  p_blank = 0, p_req = 0;

  always @(posedge clock) begin
    logic [9:0] act, exp;
    #1;
    act = {cfg_idx, r2v_f, reconf_req, blank, busy, timeout_err, unknown_code};
    exp = {4'(m_cfg), m_r2v, m_req, m_blank, m_phase != 0, m_terr, m_unk};
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL cycle %0d outputs {cfg,r2v,req,blank,busy,terr,unk}: got %b expected %b", cyc, act, exp);
    end
    if (m_req) begin
      tests++;
      if (req_idx !== 4'(m_req_idx)) begin
        fails++;
        $display("FAIL cycle %0d req_idx: got %0d expected %0d", cyc, req_idx, m_req_idx);
      end
    end
    if (blank && !p_blank) begin blank_rises++; blank_rise_cyc = cyc; end
    if (!blank && p_blank) blank_fall_cyc = cyc;
    if (reconf_req && !p_req) begin req_rises++; req_rise_cyc = cyc; req_rise_idx = int'(req_idx); end
    if (!reconf_req && p_req) req_fall_cyc = cyc;
    if (unknown_code) unk_count++;
    p_blank = blank; p_req = reconf_req;
  end

  // ---------------- ack responder
  bit ack_en = 1;
  int ack_dly = 3, age = 0;
  always @(negedge clock) begin
    if (!reconf_req) begin
      age = 0; reconf_ack = 1'b0;
    end else begin
      age++;
      reconf_ack = ack_en && (age == ack_dly);
    end
  end

  task automatic set_code(input logic [6:0] c, output int e0);
    @(negedge clock);
    data_in = {1'($urandom_range(0, 1)), c};
    e0 = cyc + 1;
  endtask

  task automatic wait_busy(input bit lvl, input int lim, input string name);
    int n = 0;
    while (busy !== lvl && n < lim) begin @(negedge clock); n++; end
    if (busy !== lvl) check({name, " wait expired"}, 0, 1);
  endtask

  initial begin
    int e0, br, uc, rr;
    logic [6:0] codes [12];
    for (int i = 0; i < 128; i++) tbl[i] = -1;
    for (int i = 0; i < 4; i++) begin
      tbl[i] = i; tbl[4 + i] = 4; tbl[8 + i] = 5; tbl[16 + i] = 6 + i;
      tbl[32 + i] = 10; tbl[64 + i] = 11;
    end
    codes = '{7'h00, 7'h01, 7'h02, 7'h03, 7'h05, 7'h0B, 7'h10, 7'h13, 7'h21, 7'h43, 7'h15, 7'h0C};

    // reset state, then steady 0x00 must never request
    repeat (3) @(negedge clock);
    check("reset cfg_idx", int'(cfg_idx), 0);
    check("reset r2v_f", int'(r2v_f), 1);
    check("reset blank", int'(blank), 0);
    check("reset busy", int'(busy), 0);
    check("reset req_idx", int'(req_idx), 0);
    reset = 1'b0;
    repeat (20) @(negedge clock);
    check("no request at code 0", req_rises, 0);

    // 0x00 -> 0x02, ack 3 cycles after request
    ack_dly = 3;
    set_code(7'h02, e0);
    wait_busy(1, 20, "seq2 start");
    wait_busy(0, 100, "seq2 end");
    check("seq2 blank rise edge", blank_rise_cyc - e0, S + 1);
    check("seq2 req after blank", req_rise_cyc - blank_rise_cyc, B);
    check("seq2 req_idx", req_rise_idx, 2);
    check("seq2 ack latency", req_fall_cyc - req_rise_cyc, 3);
    check("seq2 blank fall after ack", blank_fall_cyc - req_fall_cyc, B);
    check("seq2 cfg_idx", int'(cfg_idx), 2);
    check("seq2 r2v_f", int'(r2v_f), 0);

    // toggling 0x02/0x03 every 2 cycles, then settle at 0x03
    br = blank_rises;
    for (int i = 0; i < 5; i++) begin
      set_code(7'h03, e0); repeat (1) @(negedge clock);
      set_code(7'h02, e0); repeat (1) @(negedge clock);
    end
    set_code(7'h03, e0);
    wait_busy(1, 20, "toggle start");
    wait_busy(0, 100, "toggle end");
    repeat (20) @(negedge clock);
    check("toggle one sequence", blank_rises - br, 1);
    check("toggle start edge", blank_rise_cyc - e0, S + 1);
    check("toggle req_idx", req_rise_idx, 3);

    // unmapped code pulses once, then again only after a change
    uc = unk_count;
    set_code(7'h15, e0);
    repeat (25) @(negedge clock);
    check("unknown one pulse", unk_count - uc, 1);
    check("unknown cfg_idx", int'(cfg_idx), 3);
    check("unknown busy", int'(busy), 0);
    set_code(7'h7F, e0);
    repeat (10) @(negedge clock);
    check("unknown re-armed", unk_count - uc, 2);

    // ack withheld -> timeout, blocked until code changes
    ack_en = 0;
    set_code(7'h01, e0);
    wait_busy(1, 20, "tmo start");
    wait_busy(0, 100, "tmo end");
    check("tmo req width", req_fall_cyc - req_rise_cyc, TO);
    check("tmo err", int'(timeout_err), 1);
    check("tmo cfg_idx kept", int'(cfg_idx), 3);
    br = blank_rises;
    repeat (30) @(negedge clock);
    check("tmo no retry", blank_rises - br, 0);
    ack_en = 1; ack_dly = 2;
    set_code(7'h08, e0);
    wait_busy(1, 20, "post-tmo start");
    wait_busy(0, 100, "post-tmo end");
    check("post-tmo req_idx", req_rise_idx, 5);
    check("post-tmo cfg_idx", int'(cfg_idx), 5);
    check("tmo err sticky", int'(timeout_err), 1);

    // ack on the same edge as timeout expiry: ack wins
    ack_dly = TO;
    set_code(7'h10, e0);
    wait_busy(1, 20, "tie start");
    wait_busy(0, 100, "tie end");
    check("tie req width", req_fall_cyc - req_rise_cyc, TO);
    check("tie cfg_idx", int'(cfg_idx), 6);

    // reset while in REQ
    ack_en = 0;
    set_code(7'h11, e0);
    rr = 0;
    while (!reconf_req && rr < 40) begin @(negedge clock); rr++; end
    check("reach REQ", int'(reconf_req), 1);
    reset = 1'b1;
    @(negedge clock);
    check("rst-in-req reconf_req", int'(reconf_req), 0);
    check("rst-in-req blank", int'(blank), 0);
    check("rst-in-req cfg_idx", int'(cfg_idx), 0);
    check("rst-in-req timeout_err", int'(timeout_err), 0);
    check("rst-in-req busy", int'(busy), 0);
    reset = 1'b0; ack_en = 1;

    // randomized traffic against the model
    for (int i = 0; i < 300; i++) begin
      @(negedge clock);
      case ($urandom_range(0, 3))
        0, 1: data_in = {1'($urandom_range(0, 1)), codes[$urandom_range(0, 11)]};
        2:    data_in = 8'($urandom);
        default: data_in[7] = 1'($urandom_range(0, 1));
      endcase
      ack_dly = $urandom_range(1, 36);
      ack_en  = ($urandom_range(0, 9) != 0);
      reset   = ($urandom_range(0, 59) == 0);
      repeat ($urandom_range(1, 25)) @(negedge clock);
      reset = 1'b0;
    end
    repeat (60) @(negedge clock);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
